pipeline_sequencer: RTL
=======================

# pipeline_sequencer

Central control block for the 5-stage RV32I pipeline (IF/ID/EX/MA/WB). It sequences the boot-time instruction-memory load from the testbench port. It then runs the pipeline, generating PC/IF-ID enables and IF-ID/ID-EX flushes for load-use stalls and taken branches/jumps. On `ecall` it drains the pipeline into a halt state, and it keeps cycle, stall and flush performance counters.

## Interface
- No parameters; all widths fixed for RV32I.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `tb_valid` in 1: testbench instruction-write strobe.
- `tb_addr` in 32: byte address of the instruction word.
- `tb_inst` in 32: instruction word.
- `tb_done` in 1: load phase complete.
- `imem_we` out 1: instruction-memory write enable.
- `imem_waddr` out 32: instruction-memory write address.
- `imem_wdata` out 32: instruction-memory write data.
- `rs1_id` in 5: ID-stage source register 1.
- `rs2_id` in 5: ID-stage source register 2.
- `use_rs1_id` in 1: the ID-stage instruction reads rs1.
- `use_rs2_id` in 1: the ID-stage instruction reads rs2.
- `rd_ex` in 5: EX-stage destination register.
- `memread_ex` in 1: the EX-stage instruction is a load (WBSel = memory).
- `pcsel_ex` in 1: taken branch/jump resolved in EX.
- `ecall_ex` in 1: the EX-stage instruction is `ecall` (0x00000073).
- `pc_en` out 1: PC register update enable.
- `ifid_en` out 1: IF/ID register enable.
- `ifid_flush` out 1: IF/ID register loads a NOP.
- `idex_flush` out 1: ID/EX register loads a bubble (all write enables 0).
- `running` out 1: the FSM is in RUN.
- `halted` out 1: the FSM is in HALT.
- `load_err` out 1: sticky flag set by a misaligned `tb_addr`.
- `cycle_cnt` out 32: RUN cycles.
- `stall_cnt` out 32: load-use stall cycles.
- `flush_cnt` out 32: branch flush events.

## Operation
- FSM states: LOAD, WARM, RUN, DRAIN, HALT. `reset` forces LOAD.
- **LOAD**
  - `pc_en`=0, `ifid_en`=0, `ifid_flush`=1, `idex_flush`=1.
  - `tb_valid` with `tb_addr[1:0]`=0 produces a registered write: `imem_we`=1 on the next cycle, with `imem_waddr`/`imem_wdata` equal to the captured `tb_addr`/`tb_inst`.
  - `tb_valid` with `tb_addr[1:0]`≠0 is dropped and sets `load_err` (sticky until `reset`).
  - `tb_done`=1 moves the FSM to WARM. If `tb_valid` and `tb_done` are asserted together, the write is still performed.
- **WARM**
  - Lasts exactly 3 cycles, counted by a 2-bit counter.
  - `pc_en`=0; both flushes asserted, so stale IF/ID/EX contents are cleared.
  - Then moves to RUN.
- **RUN** (evaluated combinationally from the current inputs):
  - Branch: `pcsel_ex`=1 → `pc_en`=1, `ifid_en`=1, `ifid_flush`=1, `idex_flush`=1; `flush_cnt`+1.
  - Load-use: `memread_ex` && `rd_ex`≠0 && ((`use_rs1_id` && `rs1_id`==`rd_ex`) || (`use_rs2_id` && `rs2_id`==`rd_ex`)) → `pc_en`=0, `ifid_en`=0, `ifid_flush`=0, `idex_flush`=1; `stall_cnt`+1.
  - Priority: branch beats load-use, because the dependent instruction is being flushed. In that case only `flush_cnt` increments.
  - Otherwise: `pc_en`=1, `ifid_en`=1, both flushes 0.
  - `cycle_cnt`+1 every RUN cycle.
  - `ecall_ex`=1 moves the FSM to DRAIN. `ecall` has priority over a simultaneous `pcsel_ex`: no flush count and no PC update that cycle.
- **DRAIN**
  - Lasts exactly 2 cycles, so the instructions in MA and WB retire.
  - `pc_en`=0, `ifid_en`=0, both flushes 1.
  - Then moves to HALT.
- **HALT**
  - Same outputs as DRAIN; `halted`=1.
  - Remains until `reset`. `tb_*` inputs are ignored.
- Counters are 32-bit and wrap modulo 2^32.
- `tb_*` inputs are ignored outside LOAD.

## Timing
- Reset values, visible on the cycle after `reset` is sampled high:
  - FSM = LOAD.
  - `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0.
  - `running`=0, `halted`=0, `load_err`=0, all counters 0.
  - Because the FSM is in LOAD: `pc_en`=0, `ifid_en`=0, `ifid_flush`=1, `idex_flush`=1.
- `reset` mid-RUN or mid-DRAIN aborts immediately; there is no drain.
- `imem_we` latency: 1 cycle after `tb_valid`. Back-to-back `tb_valid` gives back-to-back writes.
- Control outputs in RUN are combinational, with zero latency from `pcsel_ex` / hazard inputs.
- State-dependent outputs (`running`, `halted`, and the LOAD/WARM/DRAIN/HALT forcing) are decoded from the registered state.
- A load-use stall lasts 1 cycle. On the next cycle the load is in MA, `memread_ex`=0 and the stall releases, provided no new load is in EX.
- The cycle count of each transition is fixed:
  - `tb_done` sampled high → `running`=1 after 4 rising edges (1 to enter WARM, 3 in WARM).
  - `ecall_ex` sampled → `halted`=1 after 3 edges (1 to enter DRAIN, 2 in DRAIN).

## Test plan
- **Load:** `tb_valid` with addr 0x0, 0x4, 0x8 (data 0x00500093, 0x00100113, 0x00000073) → 3 `imem_we` pulses one cycle late, with matching addr/data. Then addr 0x6 → no write; `load_err`=1.
- **Boot:** `tb_done` pulse → 3 WARM cycles with `pc_en`=0, then `running`=1; `cycle_cnt` starts counting from 0.
- **Load-use:** `memread_ex`=1, `rd_ex`=5, `rs1_id`=5, `use_rs1_id`=1 → 1 cycle of `pc_en`=0, `ifid_en`=0, `idex_flush`=1; `stall_cnt`=1. Repeat with `rd_ex`=0 → no stall.
- **Branch:** `pcsel_ex`=1 in the same cycle as a load-use condition → `ifid_flush`=1, `idex_flush`=1, `pc_en`=1; `flush_cnt`=1, `stall_cnt` unchanged.
- **Halt:** `ecall_ex`=1 with `pcsel_ex`=1 → `flush_cnt` unchanged; 2 DRAIN cycles, then `halted`=1 held for 20 cycles, with `tb_valid` ignored.
- **Reset:** `reset` during RUN after 10 RUN cycles → next cycle is LOAD, all counters 0, `running`=0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: boot-time instruction-memory load, warm-up, run-time
// hazard/branch control for the 5-stage RV32I pipeline, ecall drain to halt,
// and cycle/stall/flush performance counters.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD   | accept tb_* instruction writes, pipeline frozen and flushed
// WARM   | 3 cycles of flushing to clear stale IF/ID/EX contents
// RUN    | normal execution, stall on load-use, flush on taken branch
// DRAIN  | 2 cycles letting MA/WB retire after ecall
// HALT   | frozen until reset, tb_* ignored
module pipeline_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        tb_valid,
  input  logic [31:0] tb_addr,
  input  logic [31:0] tb_inst,
  input  logic        tb_done,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic [4:0]  rd_ex,
  input  logic        memread_ex,
  input  logic        pcsel_ex,
  input  logic        ecall_ex,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        running,
  output logic        halted,
  output logic        load_err,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_WARM  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_tmr;
  logic        r_imem_we;
  logic [31:0] r_imem_waddr;
  logic [31:0] r_imem_wdata;
  logic        r_load_err;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_hazard;
  logic        w_stall;
  logic        w_branch;
  logic        w_load_wr;
  logic        w_load_bad;

  assign w_hazard   = memread_ex && (rd_ex != 5'd0) &&
                      ((use_rs1_id && (rs1_id == rd_ex)) ||
                       (use_rs2_id && (rs2_id == rd_ex)));
  assign w_load_wr  = (r_state == S_LOAD) && tb_valid && (tb_addr[1:0] == 2'b00);
  assign w_load_bad = (r_state == S_LOAD) && tb_valid && (tb_addr[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_next_state;
  end

  // WARM/DRAIN down-counter: loaded on entry, state advances at terminal count 0
  always_ff @(posedge clk) begin
    if (reset)                                 r_tmr <= 2'd0;
    else if ((r_state == S_LOAD) && tb_done)   r_tmr <= 2'd2;
    else if ((r_state == S_RUN) && ecall_ex)   r_tmr <= 2'd1;
    else if (r_tmr != 2'd0)                    r_tmr <= r_tmr - 2'd1;
  end

  // Registered instruction-memory write port and sticky misalignment flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_imem_we    <= 1'b0;
      r_imem_waddr <= 32'd0;
      r_imem_wdata <= 32'd0;
      r_load_err   <= 1'b0;
    end else begin
      r_imem_we <= w_load_wr;
      if (w_load_wr) begin
        r_imem_waddr <= tb_addr;
        r_imem_wdata <= tb_inst;
      end
      if (w_load_bad) r_load_err <= 1'b1;
    end
  end

  // Performance counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (r_state == S_RUN) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_stall)          r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_branch)         r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  // Next state and pipeline control; frozen-and-flushed is the default
  always_comb begin
    w_next_state = r_state;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b1;
    idex_flush   = 1'b1;
    w_stall      = 1'b0;
    w_branch     = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (tb_done) w_next_state = S_WARM;
      end
      S_WARM: begin
        if (r_tmr == 2'd0) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (ecall_ex) begin
          // ecall wins over a branch: no redirect, pipeline starts draining
          w_next_state = S_DRAIN;
        end else if (pcsel_ex) begin
          // a dependent instruction in ID is flushed anyway, so no stall
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          w_branch = 1'b1;
        end else if (w_hazard) begin
          ifid_flush = 1'b0;
          w_stall    = 1'b1;
        end else begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b0;
          idex_flush = 1'b0;
        end
      end
      S_DRAIN: begin
        if (r_tmr == 2'd0) w_next_state = S_HALT;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_LOAD;
      end
    endcase
  end

  assign imem_we    = r_imem_we;
  assign imem_waddr = r_imem_waddr;
  assign imem_wdata = r_imem_wdata;
  assign load_err   = r_load_err;
  assign running    = (r_state == S_RUN);
  assign halted     = (r_state == S_HALT);
  assign cycle_cnt  = r_cycle_cnt;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule
